// File: rtl/frame_extrema_pkg.sv
// Shared types and constants for the frame extremum tracker.
package frame_extrema_pkg;

   // Fixed width of the ripple comparator cells
   localparam int unsigned CELL_W    = 4;
   localparam int unsigned DEF_W     = 4;
   localparam int unsigned DEF_IDX_W = 8;

   // Frame tracking state
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ACCUM = 2'b01,
      HOLD  = 2'b10
   } state_t;

   // One-hot comparator result {GT,EQ,LT}
   localparam logic [2:0] GT = 3'b100;
   localparam logic [2:0] EQ = 3'b010;
   localparam logic [2:0] LT = 3'b001;

endpackage

// File: rtl/frame_extrema_cmp_cell.sv
// Ripple magnitude comparator: compares unsigned a against b, one-hot {GT,EQ,LT}.
module cmp_cell
   import frame_extrema_pkg::*;
#(
   parameter int unsigned W = CELL_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [2:0]   res
);

   logic gt;
   logic lt;

   // Ripple from LSB to MSB; a differing higher bit overrides everything below it
   always_comb begin
      gt = 1'b0;
      lt = 1'b0;
      for (int i = 0; i < int'(W); i++) begin
         gt = (a[i] & ~b[i]) | (~(a[i] ^ b[i]) & gt);
         lt = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & lt);
      end
      res = {gt, ~(gt | lt), lt};
   end

endmodule

// File: rtl/frame_extrema.sv
// Streaming unsigned max/min tracker with first-occurrence indices per frame.
module frame_extrema
   import frame_extrema_pkg::*;
#(
   parameter int unsigned W     = DEF_W,
   parameter int unsigned IDX_W = DEF_IDX_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_max,
   output logic [W-1:0]     out_min,
   output logic [IDX_W-1:0] out_max_idx,
   output logic [IDX_W-1:0] out_min_idx,
   output logic [IDX_W:0]   out_count,
   output logic             out_ovf
);

   localparam int unsigned      CNT_W   = IDX_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(1) << IDX_W;
   localparam logic [IDX_W-1:0] IDX_MAX = '1;

   state_t           state;
   logic [W-1:0]     max_q;
   logic [W-1:0]     min_q;
   logic [IDX_W-1:0] max_idx_q;
   logic [IDX_W-1:0] min_idx_q;
   logic [IDX_W-1:0] idx_q;
   logic [CNT_W-1:0] count_q;
   logic             ovf_q;

   logic [2:0]       res_a;
   logic [2:0]       res_b;
   logic             accept;

   logic [W-1:0]     nxt_max;
   logic [W-1:0]     nxt_min;
   logic [IDX_W-1:0] nxt_max_idx;
   logic [IDX_W-1:0] nxt_min_idx;
   logic [IDX_W-1:0] nxt_idx;
   logic [CNT_W-1:0] nxt_count;
   logic             nxt_ovf;

   assign accept = in_valid & in_ready;

   // Cell A: incoming sample vs running maximum
   cmp_cell #(.W(W)) u_cmp_max (
      .a   (in_data),
      .b   (max_q),
      .res (res_a)
   );

   // Cell B: incoming sample vs running minimum
   cmp_cell #(.W(W)) u_cmp_min (
      .a   (in_data),
      .b   (min_q),
      .res (res_b)
   );

   // Running-state update for the sample being accepted; non-one-hot cell output keeps
   always_comb begin
      nxt_max     = max_q;
      nxt_min     = min_q;
      nxt_max_idx = max_idx_q;
      nxt_min_idx = min_idx_q;
      nxt_idx     = idx_q;
      nxt_count   = count_q;
      nxt_ovf     = ovf_q;
      if (state == IDLE) begin
         nxt_max     = in_data;
         nxt_min     = in_data;
         nxt_max_idx = '0;
         nxt_min_idx = '0;
         nxt_idx     = IDX_W'(1);
         nxt_count   = CNT_W'(1);
         nxt_ovf     = 1'b0;
      end else begin
         if (res_a == GT) begin
            nxt_max     = in_data;
            nxt_max_idx = idx_q;
         end
         if (res_b == LT) begin
            nxt_min     = in_data;
            nxt_min_idx = idx_q;
         end
         if (count_q == CNT_MAX) begin
            nxt_ovf = 1'b1;
         end else begin
            nxt_count = count_q + CNT_W'(1);
         end
         if (idx_q != IDX_MAX) begin
            nxt_idx = idx_q + IDX_W'(1);
         end
      end
   end

   // Frame FSM, running registers and registered result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         out_max     <= '0;
         out_min     <= '0;
         out_max_idx <= '0;
         out_min_idx <= '0;
         out_count   <= '0;
         out_ovf     <= 1'b0;
         max_q       <= '0;
         min_q       <= '0;
         max_idx_q   <= '0;
         min_idx_q   <= '0;
         idx_q       <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
      end else begin
         case (state)
            IDLE, ACCUM: begin
               if (accept) begin
                  max_q     <= nxt_max;
                  min_q     <= nxt_min;
                  max_idx_q <= nxt_max_idx;
                  min_idx_q <= nxt_min_idx;
                  idx_q     <= nxt_idx;
                  count_q   <= nxt_count;
                  ovf_q     <= nxt_ovf;
                  if (in_last) begin
                     state       <= HOLD;
                     in_ready    <= 1'b0;
                     out_valid   <= 1'b1;
                     out_max     <= nxt_max;
                     out_min     <= nxt_min;
                     out_max_idx <= nxt_max_idx;
                     out_min_idx <= nxt_min_idx;
                     out_count   <= nxt_count;
                     out_ovf     <= nxt_ovf;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= IDLE;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_extrema.sv
// Directed and randomized-gap checks for frame_extrema.
module tb_frame_extrema;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_max;
   logic [3:0] out_min;
   logic [7:0] out_max_idx;
   logic [7:0] out_min_idx;
   logic [8:0] out_count;
   logic       out_ovf;

   // Narrow-index instance used for the overflow case
   logic       b_in_valid;
   logic       b_in_ready;
   logic [3:0] b_in_data;
   logic       b_in_last;
   logic       b_out_valid;
   logic       b_out_ready;
   logic [3:0] b_out_max;
   logic [3:0] b_out_min;
   logic [1:0] b_out_max_idx;
   logic [1:0] b_out_min_idx;
   logic [2:0] b_out_count;
   logic       b_out_ovf;

   int n_cmp = 0;
   int n_bad = 0;
   bit rand_gaps = 1'b0;
   bit mon_en = 1'b0;

   frame_extrema #(.W(4), .IDX_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_max(out_max), .out_min(out_min),
      .out_max_idx(out_max_idx), .out_min_idx(out_min_idx),
      .out_count(out_count), .out_ovf(out_ovf)
   );

   frame_extrema #(.W(4), .IDX_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_max(b_out_max), .out_min(b_out_min),
      .out_max_idx(b_out_max_idx), .out_min_idx(b_out_min_idx),
      .out_count(b_out_count), .out_ovf(b_out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // In-ready must be the complement of out_valid while the random phase runs
   always @(negedge clk) begin
      if (mon_en) check("rdy_vs_valid", 32'(in_ready), 32'(!out_valid));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] d, input logic l);
      int n;
      if (rand_gaps) begin
         in_valid = 1'b0;
         in_data  = 4'($urandom_range(0, 15));
         in_last  = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 2)) step();
      end
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      if (n == 50) check("ready_timeout", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      check(l ? "latency_valid" : "early_valid", 32'(out_valid), 32'(l));
   endtask

   task automatic expect_result(input logic [3:0] emax, input logic [3:0] emin,
                                input logic [7:0] emaxi, input logic [7:0] emini,
                                input logic [8:0] ecnt, input logic eovf);
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
         step();
         n++;
      end
      check("out_valid", 32'(out_valid), 32'd1);
      check("max", 32'(out_max), 32'(emax));
      check("min", 32'(out_min), 32'(emin));
      check("max_idx", 32'(out_max_idx), 32'(emaxi));
      check("min_idx", 32'(out_min_idx), 32'(emini));
      check("count", 32'(out_count), 32'(ecnt));
      check("ovf", 32'(out_ovf), 32'(eovf));
      if (rand_gaps) repeat ($urandom_range(0, 3)) step();
      out_ready = 1'b1;
      check("ready_in_hold", 32'(in_ready), 32'd0);
      step();
      out_ready = 1'b0;
      check("valid_drop", 32'(out_valid), 32'd0);
      check("ready_back", 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [3:0] bvals [6];
      int len;
      logic [3:0] d, emax, emin;
      logic [7:0] emaxi, emini;

      rst_n = 1'b0;
      in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_out_ready = 1'b0;
      repeat (2) step();

      // Reset state
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_max", 32'(out_max), 32'd0);
      check("rst_min", 32'(out_min), 32'd0);
      check("rst_count", 32'(out_count), 32'd0);
      check("rst_ovf", 32'(out_ovf), 32'd0);
      rst_n = 1'b1;
      step();

      // Basic frame with repeated extremes
      send(4'd3, 1'b0); send(4'd9, 1'b0); send(4'd2, 1'b0); send(4'd9, 1'b0); send(4'd2, 1'b1);
      expect_result(4'd9, 4'd2, 8'd1, 8'd2, 9'd5, 1'b0);

      // Single-sample frame held under backpressure with stray valid pulses
      send(4'd7, 1'b1);
      for (int i = 0; i < 4; i++) begin
         in_valid = i[0];
         in_data  = 4'd0;
         in_last  = 1'b1;
         step();
         check("hold_ready", 32'(in_ready), 32'd0);
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_max", 32'(out_max), 32'd7);
         check("hold_min", 32'(out_min), 32'd7);
         check("hold_count", 32'(out_count), 32'd1);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      expect_result(4'd7, 4'd7, 8'd0, 8'd0, 9'd1, 1'b0);

      // Full-scale extremes, ties keep first index
      send(4'hF, 1'b0); send(4'h0, 1'b0); send(4'hF, 1'b0); send(4'h0, 1'b1);
      expect_result(4'd15, 4'd0, 8'd0, 8'd1, 9'd4, 1'b0);

      // Overflow on the narrow-index instance
      bvals[0] = 4'd1; bvals[1] = 4'd1; bvals[2] = 4'd1;
      bvals[3] = 4'd1; bvals[4] = 4'd1; bvals[5] = 4'd8;
      for (int i = 0; i < 6; i++) begin
         b_in_valid = 1'b1;
         b_in_data  = bvals[i];
         b_in_last  = (i == 5);
         step();
      end
      b_in_valid = 1'b0;
      b_in_last  = 1'b0;
      check("b_valid", 32'(b_out_valid), 32'd1);
      check("b_ovf", 32'(b_out_ovf), 32'd1);
      check("b_count", 32'(b_out_count), 32'd4);
      check("b_max", 32'(b_out_max), 32'd8);
      check("b_max_idx", 32'(b_out_max_idx), 32'd3);
      check("b_min", 32'(b_out_min), 32'd1);
      check("b_min_idx", 32'(b_out_min_idx), 32'd0);
      b_out_ready = 1'b1;
      step();
      b_out_ready = 1'b0;
      check("b_valid_drop", 32'(b_out_valid), 32'd0);

      // Reset aborts a partial frame
      send(4'd12, 1'b0); send(4'd1, 1'b0); send(4'd6, 1'b0);
      rst_n = 1'b0;
      #2;
      check("abort_valid", 32'(out_valid), 32'd0);
      check("abort_ready", 32'(in_ready), 32'd1);
      check("abort_count", 32'(out_count), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      send(4'd5, 1'b0); send(4'd4, 1'b1);
      expect_result(4'd5, 4'd4, 8'd0, 8'd1, 9'd2, 1'b0);

      // Random frames with random input gaps and output backpressure
      rand_gaps = 1'b1;
      mon_en    = 1'b1;
      for (int f = 0; f < 200; f++) begin
         len = $urandom_range(1, 12);
         emax = '0; emin = '0; emaxi = '0; emini = '0;
         for (int i = 0; i < len; i++) begin
            d = 4'($urandom_range(0, 15));
            if (i == 0 || d > emax) begin emax = d; emaxi = 8'(i); end
            if (i == 0 || d < emin) begin emin = d; emini = 8'(i); end
            send(d, i == len - 1);
         end
         expect_result(emax, emin, emaxi, emini, 9'(len), 1'b0);
      end
      mon_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
